addsub_sat_pipe: RTL and testbench

ADDSUB_SAT_PIPE -- requirements
Module: addsub_sat_pipe

---
 rtl/addsub_sat_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_addsub_sat_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_sat_pipe.sv
// ---------------------------------------------------------------------------
// addsub_sat_pipe
//   Two-stage pipelined signed adder/subtractor with optional saturation and
//   a packed (per-lane) SIMD mode. Stage 1 captures operands and control;
//   stage 2 captures the computed result and its flags. Valid/ready
//   handshakes on both sides; in_ready is combinational from pipeline
//   occupancy and out_ready.
//
// Parameters
//   WIDTH  datapath width in bits
//   LANE   lane width in packed mode (WIDTH must be a multiple, LANE >= 2)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   input transaction present
//   in_ready   block accepts an input this cycle
//   a, b       signed operands
//   op         00 ADD, 01 SUB (a-b), 10 PADD, 11 PSUB
//   sat_en     1 = saturate on overflow, 0 = wrap
//   out_valid  result present
//   out_ready  downstream accepts the result
//   result     final (post-saturation) result
//   ovfl       signed overflow (OR of lanes in packed mode)
//   lane_ovfl  per-lane overflow in packed mode, zero otherwise
//   n, z       sign and zero of result
// ---------------------------------------------------------------------------
module addsub_sat_pipe #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4,
  localparam int NL   = WIDTH / LANE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovfl,
  output logic [NL-1:0]    lane_ovfl,
  output logic             n,
  output logic             z
);

  localparam logic [WIDTH-1:0] FULL_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] FULL_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LANE-1:0]  LANE_MAX = {1'b0, {(LANE-1){1'b1}}};
  localparam logic [LANE-1:0]  LANE_MIN = {1'b1, {(LANE-1){1'b0}}};

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             sat_q, sat_d;

  // Stage 2 state
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovfl_q, ovfl_d;
  logic [NL-1:0]    lane_ovfl_q, lane_ovfl_d;
  logic             n_q, n_d;
  logic             z_q, z_d;

  // Handshake / datapath intermediates
  logic             s1_load_s;
  logic             s2_load_s;
  logic             sub_s;
  logic             packed_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH-1:0] full_raw_s;
  logic             full_ov_s;
  logic [WIDTH-1:0] lane_res_s;
  logic [NL-1:0]    lane_ov_s;
  logic [WIDTH-1:0] res_s;
  logic             ov_s;
  logic [NL-1:0]    lov_s;

  assign in_ready  = !s1_valid_q || !s2_valid_q || out_ready;
  assign s1_load_s = in_valid && in_ready;
  assign s2_load_s = s1_valid_q && (!s2_valid_q || out_ready);

  // Subtraction is a + ~b + 1; the overflow test uses the inverted b sign.
  assign sub_s      = op_q[0];
  assign packed_s   = op_q[1];
  assign b_eff_s    = sub_s ? ~b_q : b_q;
  assign full_raw_s = a_q + b_eff_s + {{(WIDTH-1){1'b0}}, sub_s};
  assign full_ov_s  = (a_q[WIDTH-1] == b_eff_s[WIDTH-1]) &&
                      (full_raw_s[WIDTH-1] != a_q[WIDTH-1]);

  // Each lane is an independent adder: carry-in is the subtract bit, carry-out is dropped.
  for (genvar g = 0; g < NL; g++) begin : g_lane
    logic [LANE-1:0] la_s;
    logic [LANE-1:0] lb_s;
    logic [LANE-1:0] lr_s;
    assign la_s = a_q[g*LANE +: LANE];
    assign lb_s = b_eff_s[g*LANE +: LANE];
    assign lr_s = la_s + lb_s + {{(LANE-1){1'b0}}, sub_s};
    assign lane_ov_s[g] = (la_s[LANE-1] == lb_s[LANE-1]) && (lr_s[LANE-1] != la_s[LANE-1]);
    // On overflow the operand sign gives the direction: positive -> max, negative -> min.
    assign lane_res_s[g*LANE +: LANE] = (sat_q && lane_ov_s[g]) ?
                                        (la_s[LANE-1] ? LANE_MIN : LANE_MAX) : lr_s;
  end

  // Select full-width or packed result and flags from the stage-1 contents.
  always_comb begin
    res_s = full_raw_s;
    ov_s  = 1'b0;
    lov_s = {NL{1'b0}};
    if (packed_s) begin
      res_s = lane_res_s;
      ov_s  = |lane_ov_s;
      lov_s = lane_ov_s;
    end else begin
      ov_s  = full_ov_s;
      lov_s = {NL{1'b0}};
      if (sat_q && full_ov_s) begin
        res_s = a_q[WIDTH-1] ? FULL_MIN : FULL_MAX;
      end else begin
        res_s = full_raw_s;
      end
    end
  end

  // Next-state for both pipeline stages.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    sat_d       = sat_q;
    s2_valid_d  = s2_valid_q;
    res_d       = res_q;
    ovfl_d      = ovfl_q;
    lane_ovfl_d = lane_ovfl_q;
    n_d         = n_q;
    z_d         = z_q;

    // When S1 can take new data it either refills or empties.
    if (in_ready) begin
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s1_load_s) begin
      a_d   = a;
      b_d   = b;
      op_d  = op;
      sat_d = sat_en;
    end else begin
      a_d   = a_q;
      b_d   = b_q;
      op_d  = op_q;
      sat_d = sat_q;
    end

    // S2 data only changes on a load, so a stalled result stays stable.
    if (s2_load_s) begin
      s2_valid_d  = 1'b1;
      res_d       = res_s;
      ovfl_d      = ov_s;
      lane_ovfl_d = lov_s;
      n_d         = res_s[WIDTH-1];
      z_d         = (res_s == {WIDTH{1'b0}});
    end else if (out_ready) begin
      s2_valid_d  = 1'b0;
    end else begin
      s2_valid_d  = s2_valid_q;
    end
  end

  // Pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      op_q        <= 2'b00;
      sat_q       <= 1'b0;
      s2_valid_q  <= 1'b0;
      res_q       <= {WIDTH{1'b0}};
      ovfl_q      <= 1'b0;
      lane_ovfl_q <= {NL{1'b0}};
      n_q         <= 1'b0;
      z_q         <= 1'b1;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      sat_q       <= sat_d;
      s2_valid_q  <= s2_valid_d;
      res_q       <= res_d;
      ovfl_q      <= ovfl_d;
      lane_ovfl_q <= lane_ovfl_d;
      n_q         <= n_d;
      z_q         <= z_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = res_q;
  assign ovfl      = ovfl_q;
  assign lane_ovfl = lane_ovfl_q;
  assign n         = n_q;
  assign z         = z_q;

endmodule

// File: tb/tb_addsub_sat_pipe.sv
// ---------------------------------------------------------------------------
// tb_addsub_sat_pipe
//   Directed table of hand-computed vectors, backpressure and mid-flight
//   reset sequences, and a random stream checked against an integer model.
// ---------------------------------------------------------------------------
module tb_addsub_sat_pipe;

  typedef struct packed {
    logic [15:0] res;
    logic        ov;
    logic [3:0]  lov;
    logic        nn;
    logic        zz;
  } exp_t;

  typedef struct packed {
    logic [15:0] va;
    logic [15:0] vb;
    logic [1:0]  vop;
    logic        vsat;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  op;
  logic        sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        ovfl;
  logic [3:0]  lane_ovfl;
  logic        n;
  logic        z;

  int   checks = 0;
  int   passes = 0;
  exp_t q[$];
  logic hold_pending = 1'b0;
  exp_t held;
  vec_t tab[$];

  addsub_sat_pipe #(.WIDTH(16), .LANE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovfl(ovfl), .lane_ovfl(lane_ovfl), .n(n), .z(z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [15:0] va, vb, input logic [1:0] vop, input logic vsat,
                              input logic [15:0] res, input logic ov, input logic [3:0] lov,
                              input logic nn, input logic zz);
    vec_t v;
    v.va = va; v.vb = vb; v.vop = vop; v.vsat = vsat;
    v.e.res = res; v.e.ov = ov; v.e.lov = lov; v.e.nn = nn; v.e.zz = zz;
    return v;
  endfunction

  // Arithmetic reference using integer ranges rather than bit tricks.
  function automatic exp_t model(input logic [15:0] ma, mb, input logic [1:0] mop, input logic msat);
    exp_t r;
    int s, sa, sb;
    logic [3:0] la, lb, lr;
    r = '0;
    if (!mop[1]) begin
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      s  = mop[0] ? sa - sb : sa + sb;
      if (s > 32767) begin
        r.ov = 1'b1; r.res = msat ? 16'h7FFF : 16'(s);
      end else if (s < -32768) begin
        r.ov = 1'b1; r.res = msat ? 16'h8000 : 16'(s);
      end else begin
        r.res = 16'(s);
      end
    end else begin
      for (int l = 0; l < 4; l++) begin
        la = ma[l*4 +: 4];
        lb = mb[l*4 +: 4];
        sa = int'($signed(la));
        sb = int'($signed(lb));
        s  = mop[0] ? sa - sb : sa + sb;
        if (s > 7) begin
          r.lov[l] = 1'b1; lr = msat ? 4'h7 : 4'(s);
        end else if (s < -8) begin
          r.lov[l] = 1'b1; lr = msat ? 4'h8 : 4'(s);
        end else begin
          lr = 4'(s);
        end
        r.res[l*4 +: 4] = lr;
      end
      r.ov = |r.lov;
    end
    r.nn = r.res[15];
    r.zz = (r.res == 16'h0000);
    return r;
  endfunction

  // One clock cycle: drive at negedge, sample 1 time unit later, score handshakes.
  task automatic cycle(input logic iv, input vec_t v, input logic ordy, input logic use_tab,
                       output logic accepted);
    exp_t cur;
    exp_t want;
    @(negedge clk);
    in_valid  = iv;
    a         = v.va;
    b         = v.vb;
    op        = v.vop;
    sat_en    = v.vsat;
    out_ready = ordy;
    #1;
    cur = {result, ovfl, lane_ovfl, n, z};
    if (hold_pending) begin
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_data", {41'd0, cur}, {41'd0, held});
    end
    if (out_valid && out_ready) begin
      chk("out_expected", {63'd0, (q.size() != 0)}, 64'd1);
      if (q.size() != 0) begin
        want = q.pop_front();
        chk("out_data", {41'd0, cur}, {41'd0, want});
      end
    end
    hold_pending = out_valid && !out_ready;
    held = cur;
    accepted = iv && in_ready;
    if (accepted) q.push_back(use_tab ? v.e : model(v.va, v.vb, v.vop, v.vsat));
  endtask

  // Single transaction with latency check: low in the cycle after acceptance, high the next.
  task automatic run_vec(input vec_t v);
    logic acc;
    cycle(1'b1, v, 1'b1, 1'b1, acc);
    chk("tab_accept", {63'd0, acc}, 64'd1);
    cycle(1'b0, v, 1'b1, 1'b1, acc);
    chk("tab_latency_early", {63'd0, out_valid}, 64'd0);
    cycle(1'b0, v, 1'b1, 1'b1, acc);
    chk("tab_latency_valid", {63'd0, out_valid}, 64'd1);
  endtask

  initial begin
    logic acc;
    int   idx;
    int   guard;
    vec_t rv;

    tab.push_back(mk(16'h7000, 16'h2000, 2'b00, 1'b1, 16'h7FFF, 1'b1, 4'h0, 1'b0, 1'b0));
    tab.push_back(mk(16'h7000, 16'h2000, 2'b00, 1'b0, 16'h9000, 1'b1, 4'h0, 1'b1, 1'b0));
    tab.push_back(mk(16'h8000, 16'h0001, 2'b01, 1'b1, 16'h8000, 1'b1, 4'h0, 1'b1, 1'b0));
    tab.push_back(mk(16'h0001, 16'hFFFF, 2'b00, 1'b1, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b1));
    tab.push_back(mk(16'h7F80, 16'h1181, 2'b10, 1'b1, 16'h7081, 1'b1, 4'hA, 1'b0, 1'b0));
    tab.push_back(mk(16'h7F80, 16'h1181, 2'b10, 1'b0, 16'h8001, 1'b1, 4'hA, 1'b1, 1'b0));
    tab.push_back(mk(16'h1234, 16'h1111, 2'b11, 1'b1, 16'h0123, 1'b0, 4'h0, 1'b0, 1'b0));
    tab.push_back(mk(16'h8070, 16'h1010, 2'b11, 1'b1, 16'h8060, 1'b1, 4'h8, 1'b1, 1'b0));
    tab.push_back(mk(16'h0700, 16'h0800, 2'b11, 1'b0, 16'h0F00, 1'b1, 4'h4, 1'b0, 1'b0));
    tab.push_back(mk(16'h0700, 16'h0800, 2'b11, 1'b1, 16'h0700, 1'b1, 4'h4, 1'b0, 1'b0));
    tab.push_back(mk(16'h0000, 16'h8000, 2'b01, 1'b1, 16'h7FFF, 1'b1, 4'h0, 1'b0, 1'b0));
    tab.push_back(mk(16'h1234, 16'h1234, 2'b01, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b1));
    tab.push_back(mk(16'h8000, 16'h8000, 2'b00, 1'b1, 16'h8000, 1'b1, 4'h0, 1'b1, 1'b0));
    tab.push_back(mk(16'h8000, 16'h8000, 2'b00, 1'b0, 16'h0000, 1'b1, 4'h0, 1'b0, 1'b1));
    tab.push_back(mk(16'hFFFE, 16'h0001, 2'b00, 1'b0, 16'hFFFF, 1'b0, 4'h0, 1'b1, 1'b0));
    tab.push_back(mk(16'h8888, 16'hFFFF, 2'b10, 1'b1, 16'h8888, 1'b1, 4'hF, 1'b1, 1'b0));
    tab.push_back(mk(16'h8888, 16'hFFFF, 2'b10, 1'b0, 16'h7777, 1'b1, 4'hF, 1'b0, 1'b0));

    rst = 1'b1; in_valid = 1'b0; a = 16'h0000; b = 16'h0000;
    op = 2'b00; sat_en = 1'b0; out_ready = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_outputs", {41'd0, result, ovfl, lane_ovfl, n, z}, {41'd0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b1});
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < tab.size(); i++) run_vec(tab[i]);

    // Backpressure: 6 stalled cycles offering three distinct inputs
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, tab[(idx == 0) ? 0 : (idx == 1) ? 4 : 6], 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    guard = 0;
    while ((idx < 3 || q.size() != 0) && guard < 20) begin
      cycle(idx < 3, tab[(idx == 0) ? 0 : (idx == 1) ? 4 : 6], 1'b1, 1'b0, acc);
      if (acc) idx++;
      guard++;
    end
    chk("bp_all_accepted", idx, 3);
    chk("bp_drained", q.size(), 0);
    cycle(1'b0, tab[0], 1'b1, 1'b0, acc);
    cycle(1'b0, tab[0], 1'b1, 1'b0, acc);

    // Reset with both stages full
    cycle(1'b1, tab[1], 1'b0, 1'b0, acc);
    chk("rstfill_acc0", {63'd0, acc}, 64'd1);
    cycle(1'b1, tab[2], 1'b0, 1'b0, acc);
    chk("rstfill_acc1", {63'd0, acc}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstfill_full", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    #1;
    chk("rstmid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rstmid_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rstmid_outputs", {41'd0, result, ovfl, lane_ovfl, n, z}, {41'd0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b1});
    q.delete();
    hold_pending = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_vec(tab[4]);
    cycle(1'b0, tab[0], 1'b1, 1'b0, acc);
    chk("rst_no_stale", {63'd0, out_valid}, 64'd0);

    // Random stream against the model
    for (int c = 0; c < 400; c++) begin
      rv.va   = 16'($urandom);
      rv.vb   = 16'($urandom);
      rv.vop  = 2'($urandom_range(0, 3));
      rv.vsat = 1'($urandom_range(0, 1));
      rv.e    = '0;
      cycle(1'($urandom_range(0, 1)), rv, ($urandom_range(0, 3) != 0), 1'b0, acc);
    end
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      cycle(1'b0, rv, 1'b1, 1'b0, acc);
      guard++;
    end
    chk("rand_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
